// File: rtl/sample_discriminator_config_sequencer.sv
// Stages discriminator config words and commits dirty registers as single AXIS beats.
// Optional handshake timeout: SAMPLE_DISCRIMINATOR_CONFIG_SEQ_TIMEOUT_EN.
module sample_discriminator_config_sequencer #(
    parameter int CHANNELS       = 8,
    parameter int TX_CHANNELS    = 8,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int TIMER_BITS     = 6,
    parameter int SOURCE_BITS    = $clog2(CHANNELS + TX_CHANNELS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 ps_clk,
    input  logic                                 ps_reset,
    input  logic [43:0]                          ps_cmd_data,
    input  logic                                 ps_cmd_valid,
    output logic                                 ps_cmd_ready,
    output logic [2*CHANNELS*SAMPLE_WIDTH-1:0]   ps_thresholds_data,
    output logic                                 ps_thresholds_valid,
    output logic                                 ps_thresholds_last,
    input  logic                                 ps_thresholds_ready,
    output logic [3*CHANNELS*TIMER_BITS-1:0]     ps_delays_data,
    output logic                                 ps_delays_valid,
    output logic                                 ps_delays_last,
    input  logic                                 ps_delays_ready,
    output logic [CHANNELS*SOURCE_BITS-1:0]      ps_trigger_select_data,
    output logic                                 ps_trigger_select_valid,
    output logic                                 ps_trigger_select_last,
    input  logic                                 ps_trigger_select_ready,
    output logic [CHANNELS-1:0]                  ps_bypass_discriminator_data,
    output logic                                 ps_bypass_discriminator_valid,
    output logic                                 ps_bypass_discriminator_last,
    input  logic                                 ps_bypass_discriminator_ready,
    output logic                                 busy,
    output logic                                 commit_done,
    output logic [1:0]                           error,
    output logic [15:0]                          commit_count
);

    localparam int THR_W  = 2 * CHANNELS * SAMPLE_WIDTH;
    localparam int DLY_W  = 3 * CHANNELS * TIMER_BITS;
    localparam int SRC_W  = CHANNELS * SOURCE_BITS;
    localparam int BYP_W  = CHANNELS;
    localparam int THR_N  = (THR_W + 31) / 32;
    localparam int DLY_N  = (DLY_W + 31) / 32;
    localparam int SRC_N  = (SRC_W + 31) / 32;
    localparam int BYP_N  = (BYP_W + 31) / 32;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_THR, S_DLY, S_SRC, S_BYP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [THR_W-1:0]    thr_q, thr_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [BYP_W-1:0]    byp_q, byp_d;
    logic [3:0]          dirty_q, dirty_d;
    logic [1:0]          err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic [THR_N*32-1:0] thr_pad;
    logic [DLY_N*32-1:0] dly_pad;
    logic [SRC_N*32-1:0] src_pad;
    logic [BYP_N*32-1:0] byp_pad;
    logic [1:0]          op;
    logic [1:0]          sel;
    logic [31:0]         payload;
    int                  widx;
    logic                hs;
    logic [3:0]          send_bit;
    logic                tmo_hit;

    function automatic state_t first_dirty(input logic [3:0] d);
        if (d[0])      return S_THR;
        else if (d[1]) return S_DLY;
        else if (d[2]) return S_SRC;
        else if (d[3]) return S_BYP;
        else           return S_DONE;
    endfunction

    assign op      = ps_cmd_data[43:42];
    assign sel     = ps_cmd_data[41:40];
    assign widx    = int'(ps_cmd_data[39:32]);
    assign payload = ps_cmd_data[31:0];

    assign ps_cmd_ready = (state_q == S_IDLE) & ~ps_reset;

    assign ps_thresholds_valid           = (state_q == S_THR);
    assign ps_delays_valid               = (state_q == S_DLY);
    assign ps_trigger_select_valid       = (state_q == S_SRC);
    assign ps_bypass_discriminator_valid = (state_q == S_BYP);
    assign ps_thresholds_last            = ps_thresholds_valid;
    assign ps_delays_last                = ps_delays_valid;
    assign ps_trigger_select_last        = ps_trigger_select_valid;
    assign ps_bypass_discriminator_last  = ps_bypass_discriminator_valid;
    assign ps_thresholds_data            = thr_q;
    assign ps_delays_data                = dly_q;
    assign ps_trigger_select_data        = src_q;
    assign ps_bypass_discriminator_data  = byp_q;

    assign busy         = (state_q != S_IDLE);
    assign commit_done  = (state_q == S_DONE);
    assign error        = err_q;
    assign commit_count = cnt_q;

`ifdef SAMPLE_DISCRIMINATOR_CONFIG_SEQ_TIMEOUT_EN
    assign tmo_hit = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        hs       = 1'b0;
        send_bit = 4'b0000;
        unique case (state_q)
            S_THR: begin
                hs       = ps_thresholds_ready;
                send_bit = 4'b0001;
            end
            S_DLY: begin
                hs       = ps_delays_ready;
                send_bit = 4'b0010;
            end
            S_SRC: begin
                hs       = ps_trigger_select_ready;
                send_bit = 4'b0100;
            end
            S_BYP: begin
                hs       = ps_bypass_discriminator_ready;
                send_bit = 4'b1000;
            end
            default: begin
                hs       = 1'b0;
                send_bit = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        tcnt_d  = '0;
        thr_pad = '0;
        dly_pad = '0;
        src_pad = '0;
        byp_pad = '0;
        thr_pad[THR_W-1:0] = thr_q;
        dly_pad[DLY_W-1:0] = dly_q;
        src_pad[SRC_W-1:0] = src_q;
        byp_pad[BYP_W-1:0] = byp_q;

        unique case (state_q)
            S_IDLE: begin
                if (ps_cmd_valid && ps_cmd_ready) begin
                    unique case (op)
                        2'd0: begin
                            // Out-of-range word index flags an error and leaves staging alone
                            unique case (sel)
                                2'd0: if (widx < THR_N) begin
                                    thr_pad[widx*32 +: 32] = payload;
                                    dirty_d[0] = 1'b1;
                                end else err_d[0] = 1'b1;
                                2'd1: if (widx < DLY_N) begin
                                    dly_pad[widx*32 +: 32] = payload;
                                    dirty_d[1] = 1'b1;
                                end else err_d[0] = 1'b1;
                                2'd2: if (widx < SRC_N) begin
                                    src_pad[widx*32 +: 32] = payload;
                                    dirty_d[2] = 1'b1;
                                end else err_d[0] = 1'b1;
                                default: if (widx < BYP_N) begin
                                    byp_pad[widx*32 +: 32] = payload;
                                    dirty_d[3] = 1'b1;
                                end else err_d[0] = 1'b1;
                            endcase
                        end
                        2'd1: begin
                            state_d = first_dirty(dirty_q);
                            tmo_d   = 1'b0;
                        end
                        2'd2: dirty_d = 4'b0000;
                        default: err_d = 2'b00;
                    endcase
                end
            end
            S_THR, S_DLY, S_SRC, S_BYP: begin
                if (hs) begin
                    dirty_d = dirty_q & ~send_bit;
                    state_d = first_dirty(dirty_d);
                end else if (tmo_hit) begin
                    err_d[1] = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!tmo_q) cnt_d = cnt_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        thr_d = thr_pad[THR_W-1:0];
        dly_d = dly_pad[DLY_W-1:0];
        src_d = src_pad[SRC_W-1:0];
        byp_d = byp_pad[BYP_W-1:0];
    end

    always_ff @(posedge ps_clk) begin
        if (ps_reset) begin
            state_q <= S_IDLE;
            thr_q   <= '0;
            dly_q   <= '0;
            src_q   <= '0;
            byp_q   <= '1;
            dirty_q <= 4'b1111;
            err_q   <= 2'b00;
            cnt_q   <= 16'd0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            dly_q   <= dly_d;
            src_q   <= src_d;
            byp_q   <= byp_d;
            dirty_q <= dirty_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_sample_discriminator_config_sequencer.sv
// Randomized bench for the config sequencer against a register-level model.
// Timeout scenario only runs when SAMPLE_DISCRIMINATOR_CONFIG_SEQ_TIMEOUT_EN is defined.
module tb_sample_discriminator_config_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [43:0]  cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] thr_data;
    logic [143:0] dly_data;
    logic [31:0]  src_data;
    logic [7:0]   byp_data;
    logic         thr_valid, dly_valid, src_valid, byp_valid;
    logic         thr_last, dly_last, src_last, byp_last;
    logic         thr_ready, dly_ready, src_ready, byp_ready;
    logic         busy, commit_done;
    logic [1:0]   error;
    logic [15:0]  commit_count;

    always #5 clk = ~clk;

    sample_discriminator_config_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .ps_clk                        (clk),
        .ps_reset                      (rst),
        .ps_cmd_data                   (cmd_data),
        .ps_cmd_valid                  (cmd_valid),
        .ps_cmd_ready                  (cmd_ready),
        .ps_thresholds_data            (thr_data),
        .ps_thresholds_valid           (thr_valid),
        .ps_thresholds_last            (thr_last),
        .ps_thresholds_ready           (thr_ready),
        .ps_delays_data                (dly_data),
        .ps_delays_valid               (dly_valid),
        .ps_delays_last                (dly_last),
        .ps_delays_ready               (dly_ready),
        .ps_trigger_select_data        (src_data),
        .ps_trigger_select_valid       (src_valid),
        .ps_trigger_select_last        (src_last),
        .ps_trigger_select_ready       (src_ready),
        .ps_bypass_discriminator_data  (byp_data),
        .ps_bypass_discriminator_valid (byp_valid),
        .ps_bypass_discriminator_last  (byp_last),
        .ps_bypass_discriminator_ready (byp_ready),
        .busy                          (busy),
        .commit_done                   (commit_done),
        .error                         (error),
        .commit_count                  (commit_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // register model: index 0 thr, 1 dly, 2 src, 3 byp
    logic [255:0] m_reg [4];
    int           m_w   [4] = '{256, 144, 32, 8};
    int           m_nw  [4] = '{8, 5, 1, 1};
    logic [3:0]   m_dirty;
    logic [1:0]   m_err;
    int           m_cnt;

    typedef struct {
        int           r;
        logic [255:0] d;
    } beat_t;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] wmask(input int w);
        logic [255:0] one;
        one = 256'd1;
        if (w >= 256) return '1;
        return (one << w) - 256'd1;
    endfunction

    function automatic logic [255:0] beat_data(input int r);
        case (r)
            0: return thr_data;
            1: return 256'(dly_data);
            2: return 256'(src_data);
            default: return 256'(byp_data);
        endcase
    endfunction

    task automatic model_reset();
        m_reg[0] = '0;
        m_reg[1] = '0;
        m_reg[2] = '0;
        m_reg[3] = 256'hFF;
        m_dirty  = 4'hF;
        m_err    = 2'b00;
        m_cnt    = 0;
    endtask

    task automatic set_ready(input logic v);
        thr_ready = v;
        dly_ready = v;
        src_ready = v;
        byp_ready = v;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valids"},
            {byp_valid, src_valid, dly_valid, thr_valid}, 4'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, commit_done, 1'b0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_err"}, error, m_err);
        chk({tag, "_cnt"}, commit_count, m_cnt[15:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Non-commit command; updates model once accepted
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] sel,
                            input logic [7:0] idx, input logic [31:0] pl);
        logic [255:0] tmp;
        int           t;
        @(negedge clk);
        cmd_data  = {op, sel, idx, pl};
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 1'b0, 1'b1);
        @(posedge clk);
        case (op)
            2'd0: begin
                if (int'(idx) >= m_nw[sel]) m_err[0] = 1'b1;
                else begin
                    tmp = m_reg[sel];
                    tmp[32*int'(idx) +: 32] = pl;
                    m_reg[sel]  = tmp & wmask(m_w[sel]);
                    m_dirty[sel] = 1'b1;
                end
            end
            2'd2: m_dirty = 4'h0;
            2'd3: m_err = 2'b00;
            default: ;
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_err", error, m_err);
    endtask

    // mode 0: all ready, 1: random backpressure, 2: delays never ready
    task automatic do_commit(input int mode);
        beat_t      q[$];
        logic [3:0] v;
        logic       rdy;
        int         r, cyc, stall, nbeats, dly_cyc;
        for (int i = 0; i < 4; i++)
            if (m_dirty[i]) q.push_back('{r: i, d: m_reg[i]});
        nbeats = q.size();
        @(negedge clk);
        cmd_data  = {2'd1, 2'd0, 8'd0, 32'd0};
        cmd_valid = 1'b1;
        chk("commit_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; stall = 0; dly_cyc = 0;
        while (cyc < 200 && !commit_done) begin
            v = {byp_valid, src_valid, dly_valid, thr_valid};
            chk("busy", busy, 1'b1);
            chk("last", {byp_last, src_last, dly_last, thr_last}, v);
            if (v != 4'h0) begin
                chk("onehot", $countones(v), 1);
                r = 0;
                for (int i = 0; i < 4; i++) if (v[i]) r = i;
                if (q.size() > 0) begin
                    chk("beat_reg", r, q[0].r);
                    chk("beat_data", beat_data(r), q[0].d);
                end else chk("extra_beat", r, 99);
                if (r == 1) dly_cyc++;
                set_ready(1'($urandom));
                if (mode == 0) rdy = 1'b1;
                else if (mode == 2) rdy = (r != 1);
                else rdy = (stall >= 3) ? 1'b1 : 1'($urandom);
                case (r)
                    0: thr_ready = rdy;
                    1: dly_ready = rdy;
                    2: src_ready = rdy;
                    default: byp_ready = rdy;
                endcase
                if (mode == 2) dly_ready = 1'b0;
                if (rdy && q.size() > 0) begin
                    void'(q.pop_front());
                    stall = 0;
                end else stall++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", commit_done, 1'b1);
        if (mode == 0) chk("done_latency", cyc, nbeats + 1);
`ifdef SAMPLE_DISCRIMINATOR_CONFIG_SEQ_TIMEOUT_EN
        if (q.size() > 0) begin
            chk("tmo_cycles", dly_cyc, 16);
            m_err[1] = 1'b1;
            m_dirty  = 4'h0;
            foreach (q[i]) m_dirty[q[i].r] = 1'b1;
        end else begin
            m_dirty = 4'h0;
            m_cnt++;
        end
`else
        chk("beats_left", q.size(), 0);
        m_dirty = 4'h0;
        m_cnt++;
`endif
        set_ready(1'b1);
        @(negedge clk);
        check_idle("post");
    endtask

    initial begin
        int op, sel, idx;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        set_ready(1'b1);
        model_reset();
        do_reset();
        check_idle("reset");

        // defaults pushed on first commit, then a single delays word
        do_commit(0);
        send_cmd(2'd0, 2'd1, 8'd2, 32'h0000_ABCD);
        do_commit(0);
        chk("cnt2", commit_count, 16'd2);

        // out-of-range index, then clear
        send_cmd(2'd0, 2'd0, 8'd9, 32'hDEAD_BEEF);
        chk("err_range", error, 2'b01);
        send_cmd(2'd3, 2'd0, 8'd0, 32'd0);
        chk("err_clear", error, 2'b00);
        do_commit(0);

        // discarded write produces no beats
        send_cmd(2'd0, 2'd3, 8'd0, 32'h0000_0055);
        send_cmd(2'd2, 2'd0, 8'd0, 32'd0);
        do_commit(0);

        // reset in the middle of a stalled commit
        send_cmd(2'd0, 2'd2, 8'd0, $urandom);
        @(negedge clk);
        set_ready(1'b0);
        cmd_data  = {2'd1, 2'd0, 8'd0, 32'd0};
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("stall_valid", src_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valids",
            {byp_valid, src_valid, dly_valid, thr_valid}, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        set_ready(1'b1);
        model_reset();
        @(negedge clk);
        check_idle("midrst");
        do_commit(0);

        // randomized mix of writes, discards, clears and commits
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                sel = $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, 9);
                else idx = $urandom_range(0, m_nw[sel] - 1);
                send_cmd(2'd0, 2'(sel), 8'(idx), $urandom);
            end else if (op == 6) send_cmd(2'd2, 2'd0, 8'd0, 32'd0);
            else if (op == 7) send_cmd(2'd3, 2'd0, 8'd0, 32'd0);
            else do_commit(1);
        end
        do_commit(0);

`ifdef SAMPLE_DISCRIMINATOR_CONFIG_SEQ_TIMEOUT_EN
        send_cmd(2'd3, 2'd0, 8'd0, 32'd0);
        send_cmd(2'd2, 2'd0, 8'd0, 32'd0);
        send_cmd(2'd0, 2'd0, 8'd1, 32'h1234_5678);
        send_cmd(2'd0, 2'd1, 8'd4, 32'hFFFF_0F0F);
        do_commit(2);
        chk("tmo_err", error, 2'b10);
        do_commit(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
